// File: rtl/nmr_acq_wnd_gen.sv
// nmr_acq_wnd_gen: CPMG acquisition window and end-of-train pulse generator.
// A START launches a train of ECHO_NUM windows of WND_LEN cycles, spaced
// ECHO_PER cycles rise-to-rise, after DLY_CNT cycles. A one-cycle
// ACQ_WND_PULSED marks the end of the train (normal or aborted).
module nmr_acq_wnd_gen #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned NUM_W = 16
) (
  input  logic             ADC_CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] DLY_CNT,
  input  logic [CNT_W-1:0] WND_LEN,
  input  logic [CNT_W-1:0] ECHO_PER,
  input  logic [NUM_W-1:0] ECHO_NUM,
  output logic             ACQ_WND,
  output logic             ACQ_WND_PULSED,
  output logic             BUSY,
  output logic [NUM_W-1:0] ECHO_IDX
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_DELAY = 5'b00010,
    S_WND   = 5'b00100,
    S_GAP   = 5'b01000,
    S_FIN   = 5'b10000
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;       // delay count in DELAY, period count in WND/GAP
  logic [CNT_W-1:0] dly_m1_q;
  logic [CNT_W-1:0] wnd_m1_q;
  logic [CNT_W-1:0] per_m1_q;
  logic [NUM_W-1:0] last_idx_q;
  logic [NUM_W-1:0] idx_q;
  logic             acq_wnd_q;
  logic             pulsed_q;
  logic             busy_q;

  logic [CNT_W-1:0] wnd_eff_c;
  logic [CNT_W-1:0] per_eff_c;

  // Sanitise window length and period so every window has >= 1 low cycle after it
  always_comb begin
    wnd_eff_c = (WND_LEN == '0) ? CNT_W'(1) : WND_LEN;
    per_eff_c = (ECHO_PER <= wnd_eff_c) ? (wnd_eff_c + CNT_W'(1)) : ECHO_PER;
  end

  // Train sequencer: state, counters, latched config and registered outputs
  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dly_m1_q   <= '0;
      wnd_m1_q   <= '0;
      per_m1_q   <= '0;
      last_idx_q <= '0;
      idx_q      <= '0;
      acq_wnd_q  <= 1'b0;
      pulsed_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else if (ABORT && (state_q inside {S_DELAY, S_WND, S_GAP})) begin
      state_q   <= S_FIN;
      cnt_q     <= '0;
      acq_wnd_q <= 1'b0;
      pulsed_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START && (ECHO_NUM != '0)) begin
            dly_m1_q   <= DLY_CNT - CNT_W'(1);
            wnd_m1_q   <= wnd_eff_c - CNT_W'(1);
            per_m1_q   <= per_eff_c - CNT_W'(1);
            last_idx_q <= ECHO_NUM - NUM_W'(1);
            idx_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            // A zero delay opens the first window right after the START edge
            if (DLY_CNT == '0) begin
              state_q   <= S_WND;
              acq_wnd_q <= 1'b1;
            end else begin
              state_q <= S_DELAY;
            end
          end
        end

        S_DELAY: begin
          if (cnt_q == dly_m1_q) begin
            state_q   <= S_WND;
            cnt_q     <= '0;
            acq_wnd_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_WND: begin
          if (cnt_q == wnd_m1_q) begin
            acq_wnd_q <= 1'b0;
            if (idx_q == last_idx_q) begin
              state_q  <= S_FIN;
              cnt_q    <= '0;
              pulsed_q <= 1'b1;
            end else begin
              state_q <= S_GAP;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (cnt_q == per_m1_q) begin
            state_q   <= S_WND;
            cnt_q     <= '0;
            idx_q     <= idx_q + NUM_W'(1);
            acq_wnd_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_FIN: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          pulsed_q <= 1'b0;
          busy_q   <= 1'b0;
        end

        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          acq_wnd_q <= 1'b0;
          pulsed_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ACQ_WND        = acq_wnd_q;
  assign ACQ_WND_PULSED = pulsed_q;
  assign BUSY           = busy_q;
  assign ECHO_IDX       = idx_q;

endmodule

// File: tb/tb_nmr_acq_wnd_gen.sv
// Directed bench for nmr_acq_wnd_gen. Observations taken #1 after an edge
// show the values of the following cycle: START driven before edge 0 is
// cycle 0, the first observation after that edge is cycle 1.
module tb_nmr_acq_wnd_gen;

  logic        ADC_CLK;
  logic        RESET;
  logic        START;
  logic        ABORT;
  logic [31:0] DLY_CNT;
  logic [31:0] WND_LEN;
  logic [31:0] ECHO_PER;
  logic [15:0] ECHO_NUM;
  logic        ACQ_WND;
  logic        ACQ_WND_PULSED;
  logic        BUSY;
  logic [15:0] ECHO_IDX;

  int tests_run;
  int tests_failed;

  nmr_acq_wnd_gen #(.CNT_W(32), .NUM_W(16)) dut (
    .ADC_CLK        (ADC_CLK),
    .RESET          (RESET),
    .START          (START),
    .ABORT          (ABORT),
    .DLY_CNT        (DLY_CNT),
    .WND_LEN        (WND_LEN),
    .ECHO_PER       (ECHO_PER),
    .ECHO_NUM       (ECHO_NUM),
    .ACQ_WND        (ACQ_WND),
    .ACQ_WND_PULSED (ACQ_WND_PULSED),
    .BUSY           (BUSY),
    .ECHO_IDX       (ECHO_IDX)
  );

  initial ADC_CLK = 1'b0;
  always #5 ADC_CLK = ~ADC_CLK;

  // Reference waveform of the nominal train (DLY 3, WND 4, PER 10, NUM 3)
  function automatic logic s1_wnd(input int t);
    return (t >= 4 && t <= 7) || (t >= 14 && t <= 17) || (t >= 24 && t <= 27);
  endfunction
  function automatic logic s1_pls(input int t);
    return t == 28;
  endfunction
  function automatic logic s1_busy(input int t);
    return t >= 1 && t <= 28;
  endfunction
  function automatic int s1_idx(input int t);
    return (t >= 24) ? 2 : (t >= 14) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic adv();
    @(posedge ADC_CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input int cyc, input logic w, input logic p,
                         input logic b, input int idx);
    chk({tag, "_wnd"},  cyc, 32'(ACQ_WND),        32'(w));
    chk({tag, "_pls"},  cyc, 32'(ACQ_WND_PULSED), 32'(p));
    chk({tag, "_busy"}, cyc, 32'(BUSY),           32'(b));
    chk({tag, "_idx"},  cyc, 32'(ECHO_IDX),       32'(idx));
    chk({tag, "_excl"}, cyc, 32'(ACQ_WND & ACQ_WND_PULSED), 32'(0));
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    adv();
    adv();
    RESET = 1'b0;
    chk_all("rst", 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic cfg_nominal();
    DLY_CNT  = 32'd3;
    WND_LEN  = 32'd4;
    ECHO_PER = 32'd10;
    ECHO_NUM = 16'd3;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RESET = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    cfg_nominal();

    // Nominal train, ignored restart at 10, config change at 5, new train at 29
    do_reset();
    START = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      int rel;
      adv();
      START = 1'b0;
      rel = (c > 29) ? c - 29 : c;
      chk_all("nom", c, s1_wnd(rel), s1_pls(rel), s1_busy(rel), s1_idx(rel));
      if (c == 5) begin
        DLY_CNT  = 32'd0;
        WND_LEN  = 32'd1;
        ECHO_PER = 32'd2;
        ECHO_NUM = 16'd9;
      end
      if (c == 10) START = 1'b1;
      if (c == 29) begin
        cfg_nominal();
        START = 1'b1;
      end
    end

    // Degenerate operands; ABORT alongside START in IDLE must not block the start
    do_reset();
    DLY_CNT  = 32'd0;
    WND_LEN  = 32'd0;
    ECHO_PER = 32'd0;
    ECHO_NUM = 16'd2;
    START = 1'b1;
    ABORT = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      adv();
      START = 1'b0;
      ABORT = 1'b0;
      chk_all("degen", c, (c == 1) || (c == 3), c == 4, c >= 1 && c <= 4, (c >= 3) ? 1 : 0);
    end

    // ECHO_NUM of zero: START ignored
    ECHO_NUM = 16'd0;
    START = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      adv();
      START = 1'b0;
      chk_all("num0", c, 1'b0, 1'b0, 1'b0, 1);
    end

    // Abort mid-window at 15, held into the FIN cycle
    do_reset();
    cfg_nominal();
    START = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      adv();
      START = 1'b0;
      ABORT = 1'b0;
      chk_all("abort", c, (c >= 4 && c <= 7) || (c >= 14 && c <= 15), c == 16,
              c >= 1 && c <= 16, (c >= 14) ? 1 : 0);
      if (c == 15 || c == 16) ABORT = 1'b1;
    end

    // Reset mid-train at 15, restart at 17
    do_reset();
    cfg_nominal();
    START = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      adv();
      START = 1'b0;
      RESET = 1'b0;
      if (c <= 15)
        chk_all("rstmid", c, s1_wnd(c), s1_pls(c), s1_busy(c), s1_idx(c));
      else if (c <= 17)
        chk_all("rstmid", c, 1'b0, 1'b0, 1'b0, 0);
      else
        chk_all("rstmid", c, s1_wnd(c - 17), s1_pls(c - 17), s1_busy(c - 17), s1_idx(c - 17));
      if (c == 15) RESET = 1'b1;
      if (c == 17) START = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nmr_acq_wnd_gen.md
# nmr_acq_wnd_gen

Generates the per-echo acquisition window (`ACQ_WND`) and the end-of-train pulse (`ACQ_WND_PULSED`) for a CPMG echo train, in the `ADC_CLK` domain. It is the producer of the two strobes consumed by the Q-switch enable window generator and the ADC capture path. A `START` strobe launches a programmable train: an initial delay, then `ECHO_NUM` windows of `WND_LEN` cycles, spaced `ECHO_PER` cycles rise-to-rise. The block then emits a single-cycle end-of-train pulse so that downstream logic drops the Q-switch enable.

## Interface

**Parameters**
- `CNT_W`, default 32: width of the delay, window and period counters and their config ports.
- `NUM_W`, default 16: width of the echo counter and `ECHO_NUM`.

**Ports**
- `ADC_CLK`, in, 1: the single clock.
- `RESET`, in, 1: synchronous, active-high reset.
- `START`, in, 1: one-cycle launch strobe. Ignored while `BUSY` is high.
- `ABORT`, in, 1: terminates a running train.
- `DLY_CNT`, in, `CNT_W`: cycles from `START` to the first window rise.
- `WND_LEN`, in, `CNT_W`: window high time in cycles.
- `ECHO_PER`, in, `CNT_W`: window period, measured rise-to-rise.
- `ECHO_NUM`, in, `NUM_W`: number of windows.
- `ACQ_WND`, out, 1: acquisition window. Registered.
- `ACQ_WND_PULSED`, out, 1: one-cycle end-of-train strobe. Registered.
- `BUSY`, out, 1: a train is in progress.
- `ECHO_IDX`, out, `NUM_W`: 0-based index of the current or last window.

## Operation

**Config latching**
- All config inputs are latched in the cycle `START` is accepted. Later changes have no effect until the next train.

**Operand sanitising at latch**
- A `WND_LEN` of 0 is treated as 1.
- If `ECHO_PER <= WND_LEN`, the effective period is `WND_LEN + 1`, which guarantees at least one low cycle between windows.

**State machine** (one-hot): IDLE, DELAY, WND, GAP, FIN.
- IDLE → DELAY: on `START && ECHO_NUM != 0`.
  - `START` with `ECHO_NUM == 0` is ignored; all outputs stay at their reset values.
- DELAY → WND: after `DLY_CNT` cycles. With `DLY_CNT = 0` this happens in the next cycle.
- WND → GAP: after `WND_LEN` cycles, if windows remain.
- WND → FIN: after `WND_LEN` cycles, if this was the last window.
- GAP → WND: when the period counter reaches the effective period. `ECHO_IDX` increments on entry to WND, except for the first window, which has index 0.
- FIN → IDLE: unconditional, after one cycle. `ACQ_WND_PULSED` is high only in the FIN cycle.

**Output decode**
- `ACQ_WND` = (state == WND).
- `BUSY` = (state != IDLE).

**ABORT**
- In DELAY, WND or GAP: next state is FIN. `ACQ_WND` goes low in the next cycle and `ACQ_WND_PULSED` fires exactly once.
- In IDLE or FIN: ignored.
- `ABORT` and `START` both high in IDLE: `START` wins.

**Reset**
- `RESET` has priority over everything, including mid-train.
- Reset state is IDLE, with all counters cleared.

**Counter arithmetic**
- Counters are unsigned `CNT_W` and count up from 0.
- Comparisons use the latched, sanitised values.
- No counter wraps within valid operands: the maximum period is `2^CNT_W − 1`.

## Timing

**Reference cycle**
- Cycle 0 is the cycle in which `START` is sampled high at the `ADC_CLK` edge.

**Window placement**
- `BUSY` is high from cycle 1.
- The first `ACQ_WND` high cycle is cycle `DLY_CNT + 1`.
- Window k (0-based) is high for cycles `DLY_CNT + 1 + k·PER_eff` through `DLY_CNT + WND_LEN + k·PER_eff`.

**End of train**
- `ACQ_WND_PULSED` is high in the first cycle after the last window's final high cycle. `ACQ_WND` is low in that same cycle.
- `BUSY` stays high through the FIN cycle and is low in the cycle after it.
- The earliest cycle in which a new `START` is accepted is the cycle after FIN.

**Abort latency**
- `ABORT` sampled in cycle n: FIN, and therefore the pulse, occurs in cycle n+1, and `ACQ_WND` is low from cycle n+1.

**Reset values**
- `ACQ_WND` = 0, `ACQ_WND_PULSED` = 0, `BUSY` = 0, `ECHO_IDX` = 0.

**Output guarantees**
- All outputs are registered and glitch-free.
- `ACQ_WND` and `ACQ_WND_PULSED` are never high in the same cycle.

## Test plan

1. Nominal train. `DLY_CNT=3`, `WND_LEN=4`, `ECHO_PER=10`, `ECHO_NUM=3`, `START` in cycle 0:
   - `ACQ_WND` high in cycles 4–7, 14–17 and 24–27.
   - `ACQ_WND_PULSED` high in cycle 28 only.
   - `BUSY` high in cycles 1–28.
   - `ECHO_IDX` reads 0, 1 and 2 during the three windows.
2. Degenerate operands. `DLY_CNT=0`, `WND_LEN=0`, `ECHO_PER=0`, `ECHO_NUM=2`:
   - `ACQ_WND` high in cycles 1 and 3.
   - Pulse in cycle 4.
   - Separately, `ECHO_NUM=0`: no output activity and `BUSY` stays 0.
3. Abort mid-window. Same config as scenario 1, `ABORT` in cycle 15:
   - `ACQ_WND` low from cycle 16.
   - Pulse in cycle 16 only.
   - `BUSY` low from cycle 17.
   - No further windows.
4. Restart rules.
   - `START` re-asserted in cycle 10 of scenario 1: ignored, and the waveform is identical to scenario 1.
   - `START` in cycle 29: accepted, and the first window of the new train is at cycle 33.
   - Config changed in cycle 5: no effect on the running train.
5. Reset mid-train. `RESET` in cycle 15 of scenario 1:
   - All outputs are 0 from cycle 16.
   - No `ACQ_WND_PULSED`.
   - A `START` in cycle 17 is accepted normally.
6. Integration. Chain with the Q-switch enable window generator using scenario 1 stimulus:
   - `EN_QSW` rises after the first `ACQ_WND` rise.
   - `EN_QSW` falls after the cycle-28 pulse.
   - `EN_QSW` stays high across the inter-window gaps.
